// File: rtl/rr_arb4_sel.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux.
// Grants are registered and held for bounded bursts; one-cycle req->output latency.
module rr_arb4_sel #(
    parameter int unsigned BURST = 4,
    parameter int unsigned CW    = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] req_i,
    output logic [1:0] s_o,
    output logic [3:0] gnt_o,
    output logic       valid_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      s_q, s_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       others;
    logic       hold;

    // Rotating priority search starting at ptr; first set request wins.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign hold   = req_i[s_q];
    assign others = |(req_i & ~(4'b0001 << s_q));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBusy;
                    s_d     = win;
                    gnt_d   = 4'b0001 << win;
                    valid_d = 1'b1;
                    cnt_d   = CW'(1);
                    ptr_d   = win + 2'd1;
                end
            end
            StBusy: begin
                if (hold && (cnt_q < CW'(BURST))) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (hold && !others) begin
                    // Sole requester at burst end keeps the grant; restart burst.
                    cnt_d = CW'(1);
                end else if (found) begin
                    s_d     = win;
                    gnt_d   = 4'b0001 << win;
                    valid_d = 1'b1;
                    cnt_d   = CW'(1);
                    ptr_d   = win + 2'd1;
                end else begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            s_q     <= 2'd0;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_o     = s_q;
    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;

endmodule
